and_or_sweep_ctrl: RTL and testbench

//  Upstream stimulus/capture stage for the and_or gate. On start it walks all 16
//  {a,b,c,d} vectors and holds each one for HOLD_CYC cycles. It samples e, builds
//  the observed truth table and counts mismatches against EXPECTED. Gives the gate
//  a synthesizable self-check in silicon and FPGA bring-up.

---
 rtl/and_or_sweep_ctrl_if.sv | 26 ++
 rtl/and_or_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_and_or_sweep_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/and_or_sweep_ctrl_if.sv
// rtl/and_or_sweep_ctrl_if.sv - stimulus/capture bus between the sweep controller and its environment
interface and_or_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_tbl;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  vec_idx;

  modport master (
    output start, abort, e,
    input  a, b, c, d, busy, done, pass, truth_tbl, mismatch_cnt, vec_idx
  );

  modport slave (
    input  start, abort, e,
    output a, b, c, d, busy, done, pass, truth_tbl, mismatch_cnt, vec_idx
  );
endinterface

// File: rtl/and_or_sweep_ctrl.sv
// rtl/and_or_sweep_ctrl.sv - walks all 16 and_or input vectors, captures e and scores it against EXPECTED
module and_or_sweep_ctrl #(
  parameter int          HOLD_CYC = 2,
  parameter logic [15:0] EXPECTED = 16'hF888
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and_or_sweep_ctrl_if.slave    sweep
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_hold_cnt;
  logic [3:0]  r_vec_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_truth_tbl;
  logic [4:0]  r_mismatch_cnt;

  logic        w_sample;
  logic        w_miss;
  logic [4:0]  w_mismatch_next;
  logic        w_drive;

  assign w_sample        = (r_hold_cnt == HOLD_LAST);
  assign w_miss          = (sweep.e != EXPECTED[r_vec_idx]);
  assign w_mismatch_next = r_mismatch_cnt + {4'd0, w_miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_hold_cnt     <= 8'd0;
      r_vec_idx      <= 4'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_truth_tbl    <= 16'd0;
      r_mismatch_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sweep.start) begin
            r_state        <= S_DRIVE;
            r_hold_cnt     <= 8'd0;
            r_vec_idx      <= 4'd0;
            r_busy         <= 1'b1;
            r_pass         <= 1'b0;
            r_truth_tbl    <= 16'd0;
            r_mismatch_cnt <= 5'd0;
          end
        end
        S_DRIVE: begin
          // abort outranks the sample, so a late abort leaves the partial table unscored
          if (sweep.abort) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
            r_vec_idx  <= 4'd0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
          end else if (w_sample) begin
            r_truth_tbl[r_vec_idx] <= sweep.e;
            r_mismatch_cnt         <= w_mismatch_next;
            r_hold_cnt             <= 8'd0;
            if (r_vec_idx == 4'd15) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_mismatch_next == 5'd0);
            end else begin
              r_vec_idx <= r_vec_idx + 4'd1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // stimulus lines follow the vector flops only while a sweep owns the gate
  assign w_drive = (r_state != S_IDLE);

  assign sweep.a            = w_drive & r_vec_idx[3];
  assign sweep.b            = w_drive & r_vec_idx[2];
  assign sweep.c            = w_drive & r_vec_idx[1];
  assign sweep.d            = w_drive & r_vec_idx[0];
  assign sweep.busy         = r_busy;
  assign sweep.done         = r_done;
  assign sweep.pass         = r_pass;
  assign sweep.truth_tbl    = r_truth_tbl;
  assign sweep.mismatch_cnt = r_mismatch_cnt;
  assign sweep.vec_idx      = r_vec_idx;

endmodule

// File: tb/tb_and_or_sweep_ctrl.sv
// tb/tb_and_or_sweep_ctrl.sv - randomized self-check of and_or_sweep_ctrl at HOLD_CYC 1 and 2
module tb_and_or_sweep_ctrl;

  localparam logic [15:0] EXP = 16'hF888;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_start = 1'b0;
  logic        r_abort = 1'b0;
  logic        r_sel1 = 1'b0;
  logic [15:0] r_gate = EXP;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  and_or_sweep_ctrl_if if_h1 ();
  and_or_sweep_ctrl_if if_h2 ();

  logic [3:0] w_v1;
  logic [3:0] w_v2;
  assign w_v1 = {if_h1.a, if_h1.b, if_h1.c, if_h1.d};
  assign w_v2 = {if_h2.a, if_h2.b, if_h2.c, if_h2.d};

  assign if_h1.start = r_start & r_sel1;
  assign if_h1.abort = r_abort & r_sel1;
  assign if_h1.e     = r_gate[w_v1];
  assign if_h2.start = r_start & ~r_sel1;
  assign if_h2.abort = r_abort & ~r_sel1;
  assign if_h2.e     = r_gate[w_v2];

  and_or_sweep_ctrl #(.HOLD_CYC(1), .EXPECTED(EXP)) u_dut_h1 (.clk(clk), .rst_n(rst_n), .sweep(if_h1));
  and_or_sweep_ctrl #(.HOLD_CYC(2), .EXPECTED(EXP)) u_dut_h2 (.clk(clk), .rst_n(rst_n), .sweep(if_h2));

  logic [3:0]  w_abcd;
  logic        w_busy;
  logic        w_done;
  logic        w_pass;
  logic [15:0] w_tbl;
  logic [4:0]  w_mis;
  logic [3:0]  w_vec;
  assign w_abcd = r_sel1 ? w_v1 : w_v2;
  assign w_busy = r_sel1 ? if_h1.busy : if_h2.busy;
  assign w_done = r_sel1 ? if_h1.done : if_h2.done;
  assign w_pass = r_sel1 ? if_h1.pass : if_h2.pass;
  assign w_tbl  = r_sel1 ? if_h1.truth_tbl : if_h2.truth_tbl;
  assign w_mis  = r_sel1 ? if_h1.mismatch_cnt : if_h2.mismatch_cnt;
  assign w_vec  = r_sel1 ? if_h1.vec_idx : if_h2.vec_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abcd"}, 32'(w_abcd), 0);
    check({tag, "_busy"}, 32'(w_busy), 0);
    check({tag, "_done"}, 32'(w_done), 0);
    check({tag, "_pass"}, 32'(w_pass), 0);
    check({tag, "_tbl"},  32'(w_tbl), 0);
    check({tag, "_mis"},  32'(w_mis), 0);
    check({tag, "_vec"},  32'(w_vec), 0);
  endtask

  // abort_at = j means abort is sampled on edge start+j; 0 means run to completion
  task automatic run_sweep(input int abort_at, input bit hold_start);
    int          h;
    int          cnt;
    logic [15:0] mask;
    logic [15:0] diff;
    h    = r_sel1 ? 1 : 2;
    diff = r_gate ^ EXP;
    r_start = 1'b1;
    tick();
    if (!hold_start) r_start = 1'b0;
    check("start_busy", 32'(w_busy), 1);
    check("start_abcd", 32'(w_abcd), 0);
    check("start_tbl", 32'(w_tbl), 0);
    for (int j = 1; j <= 16 * h; j++) begin
      if (j == abort_at) r_abort = 1'b1;
      tick();
      r_abort = 1'b0;
      if (j == abort_at) begin
        cnt  = (j - 1) / h;
        mask = 16'((32'd1 << cnt) - 1);
        check("abort_busy", 32'(w_busy), 0);
        check("abort_abcd", 32'(w_abcd), 0);
        check("abort_vec", 32'(w_vec), 0);
        check("abort_done", 32'(w_done), 0);
        check("abort_pass", 32'(w_pass), 0);
        check("abort_tbl", 32'(w_tbl), 32'(r_gate & mask));
        check("abort_mis", 32'(w_mis), 32'($countones(diff & mask)));
        repeat (3) begin
          tick();
          check("abort_nodone", 32'(w_done), 0);
          check("abort_idle", 32'(w_busy), 0);
        end
        return;
      end
      if (j < 16 * h) begin
        check("sweep_abcd", 32'(w_abcd), 32'(j / h));
        check("sweep_busy", 32'(w_busy), 1);
        check("sweep_done", 32'(w_done), 0);
      end
    end
    check("end_done", 32'(w_done), 1);
    check("end_busy", 32'(w_busy), 0);
    check("end_vec", 32'(w_vec), 15);
    check("end_pass", 32'(w_pass), 32'(diff == 16'd0));
    check("end_tbl", 32'(w_tbl), 32'(r_gate));
    check("end_mis", 32'(w_mis), 32'($countones(diff)));
    tick();
    check("idle_done", 32'(w_done), 0);
    check("idle_busy", 32'(w_busy), 0);
    check("idle_abcd", 32'(w_abcd), 0);
    check("idle_pass_hold", 32'(w_pass), 32'(diff == 16'd0));
    check("idle_tbl_hold", 32'(w_tbl), 32'(r_gate));
    if (hold_start) begin
      tick();
      check("restart_busy", 32'(w_busy), 1);
      check("restart_done", 32'(w_done), 0);
      check("restart_tbl", 32'(w_tbl), 0);
      r_start = 1'b0;
      r_abort = 1'b1;
      tick();
      r_abort = 1'b0;
      check("restart_abort", 32'(w_busy), 0);
    end
  endtask

  initial begin
    int h;
    rst_n = 1'b0;
    repeat (2) tick();
    r_sel1 = 1'b0;
    #1 check_all_zero("rst_h2");
    r_sel1 = 1'b1;
    #1 check_all_zero("rst_h1");
    rst_n = 1'b1;
    tick();

    r_sel1 = 1'b0; r_gate = EXP;      run_sweep(0, 1'b0);
    tick();
    r_sel1 = 1'b0; r_gate = 16'h0000; run_sweep(0, 1'b0);
    tick();
    r_sel1 = 1'b0; r_gate = EXP;      run_sweep(11, 1'b0);
    tick();
    r_sel1 = 1'b1; r_gate = EXP;      run_sweep(0, 1'b1);
    tick();

    r_sel1 = 1'b0; r_gate = EXP;
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (18) tick();
    check("pre_rst_vec", 32'(w_vec), 9);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("held_rst");
    rst_n = 1'b1;
    tick();
    run_sweep(0, 1'b0);
    tick();

    r_sel1 = 1'b0; r_gate = EXP;      run_sweep(32, 1'b0);
    tick();
    r_sel1 = 1'b1; r_gate = 16'h1234; run_sweep(16, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      r_sel1 = 1'($urandom);
      r_gate = ($urandom % 3 == 0) ? EXP : 16'($urandom);
      h = r_sel1 ? 1 : 2;
      run_sweep(($urandom % 2 == 1) ? int'($urandom_range(1, 16 * h)) : 0, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
